// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the fetch stage.
//   - Jump encodings driven by the instruction decoder.
//   - Fetch FSM state enumeration.
//   - Branch-offset helper (sign-extend a 16-bit word offset to a byte offset).
package instr_fetch_pkg;

  localparam logic [1:0] JUMP_SEQ = 2'b00;  // sequential or conditional branch
  localparam logic [1:0] JUMP_REG = 2'b01;  // JR: target from Rs
  localparam logic [1:0] JUMP_TGT = 2'b10;  // J/JAL: pseudo-direct target

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } fetch_state_e;

  // Branch immediates count words; shift to bytes after sign extension.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_next_pc_calc.sv
// next_pc_calc: combinational next-PC selection for the fetch stage.
// Ports:
//   i_pc        current PC
//   i_jump      decoder jump code (11 behaves as 00)
//   i_branch    decoder branch (BNE) flag
//   i_target    26-bit J/JAL target
//   i_immediate 16-bit branch word offset
//   i_rs_value  Rs register value (JR target)
//   i_alu_zero  ALU zero flag; BNE is taken when it is low
//   o_next_pc   selected next PC
//   o_misalign  JR target not word-aligned
module next_pc_calc
  import instr_fetch_pkg::*;
(
  input  logic [31:0] i_pc,
  input  logic [1:0]  i_jump,
  input  logic        i_branch,
  input  logic [25:0] i_target,
  input  logic [15:0] i_immediate,
  input  logic [31:0] i_rs_value,
  input  logic        i_alu_zero,
  output logic [31:0] o_next_pc,
  output logic        o_misalign
);

  logic [31:0] w_pc_plus4;

  assign w_pc_plus4 = i_pc + 32'd4;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    o_next_pc  = w_pc_plus4;
    o_misalign = 1'b0;
    // Jumps are decoded before the branch, giving them priority.
    case (i_jump)
      JUMP_TGT: o_next_pc = {w_pc_plus4[31:28], i_target, 2'b00};
      JUMP_REG: begin
        o_next_pc  = i_rs_value;
        o_misalign = |i_rs_value[1:0];
      end
      default: begin
        if (i_branch && !i_alu_zero) begin
          o_next_pc = w_pc_plus4 + branch_offset(i_immediate);
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage feeding the instruction decoder.
// Owns the PC, issues one instruction-memory request at a time, holds the
// returned word for the decoder through EXEC, and advances the PC when EXEC
// ends (stall low).
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   imem_req/addr     request strobe (high through WAIT) and word address (= pc)
//   imem_valid/rdata  read response, sampled only in WAIT
//   instruction       word held for the decoder; instr_valid high in EXEC
//   pc, pc_plus4      current instruction address and its link value
//   branch, jump, target, immediate, rs_value, alu_zero  next-PC controls
//   stall             FPU busy, extends EXEC
//   fetch_err         sticky: response timeout or misaligned JR
//   instret           retired-instruction counter
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  input  logic        branch,
  input  logic [1:0]  jump,
  input  logic [25:0] target,
  input  logic [15:0] immediate,
  input  logic [31:0] rs_value,
  input  logic        alu_zero,
  input  logic        stall,
  output logic        fetch_err,
  output logic [31:0] instret
);

  localparam int              CNT_W     = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  fetch_state_e     r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instruction;
  logic             r_instr_valid;
  logic             r_imem_req;
  logic             r_fetch_err;
  logic [31:0]      r_instret;
  logic [CNT_W-1:0] r_wait_cnt;

  logic [31:0]      w_next_pc;
  logic             w_misalign;

  next_pc_calc u_next_pc_calc (
    .i_pc        (r_pc),
    .i_jump      (jump),
    .i_branch    (branch),
    .i_target    (target),
    .i_immediate (immediate),
    .i_rs_value  (rs_value),
    .i_alu_zero  (alu_zero),
    .o_next_pc   (w_next_pc),
    .o_misalign  (w_misalign)
  );

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset wins over any in-flight response; FETCH re-issues the request.
      r_state       <= FETCH;
      r_pc          <= RESET_PC;
      r_instruction <= '0;
      r_instr_valid <= 1'b0;
      r_imem_req    <= 1'b0;
      r_fetch_err   <= 1'b0;
      r_instret     <= '0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        FETCH: begin
          r_imem_req <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= WAIT;
        end
        WAIT: begin
          if (imem_valid) begin
            r_instruction <= imem_rdata;
            r_instr_valid <= 1'b1;
            r_imem_req    <= 1'b0;
            r_state       <= EXEC;
          end else if (r_wait_cnt == WAIT_LAST) begin
            r_fetch_err <= 1'b1;
            r_imem_req  <= 1'b0;
            r_state     <= HALT;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
        end
        EXEC: begin
          // Decoder inputs are only consumed on the exit edge, so a redirect
          // requested during a stall takes effect once stall drops.
          if (!stall) begin
            r_instret     <= r_instret + 32'd1;
            r_instr_valid <= 1'b0;
            if (w_misalign) begin
              r_fetch_err <= 1'b1;
              r_state     <= HALT;
            end else begin
              r_pc    <= w_next_pc;
              r_state <= FETCH;
            end
          end
        end
        HALT: begin
          r_imem_req    <= 1'b0;
          r_instr_valid <= 1'b0;
        end
        default: r_state <= HALT;
      endcase
    end
  end

  assign imem_req    = r_imem_req;
  assign imem_addr   = r_pc;
  assign instruction = r_instruction;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign pc_plus4    = r_pc + 32'd4;
  assign fetch_err   = r_fetch_err;
  assign instret     = r_instret;

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: expected instruction words go to a scoreboard queue
// when the memory response is driven and are popped when EXEC is observed.
// Inputs change on the falling edge; outputs are sampled there too.
module tb_instr_fetch;
  import instr_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        branch;
  logic [1:0]  jump;
  logic [25:0] target;
  logic [15:0] immediate;
  logic [31:0] rs_value;
  logic        alu_zero;
  logic        stall;
  logic        fetch_err;
  logic [31:0] instret;

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] sb_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  always #5 clk = ~clk;

  instr_fetch #(
    .RESET_PC (32'h0000_0000),
    .MAX_WAIT (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_valid  (imem_valid),
    .imem_rdata  (imem_rdata),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .branch      (branch),
    .jump        (jump),
    .target      (target),
    .immediate   (immediate),
    .rs_value    (rs_value),
    .alu_zero    (alu_zero),
    .stall       (stall),
    .fetch_err   (fetch_err),
    .instret     (instret)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic idle_inputs();
    imem_valid = 1'b0;
    imem_rdata = 32'h0;
    branch     = 1'b0;
    jump       = JUMP_SEQ;
    target     = '0;
    immediate  = '0;
    rs_value   = '0;
    alu_zero   = 1'b0;
    stall      = 1'b0;
  endtask

  // Holds reset for n cycles, checks the reset state, releases at a falling edge.
  task automatic apply_reset(input int n);
    reset = 1'b1;
    idle_inputs();
    repeat (n) @(negedge clk);
    check("rst_pc",      pc,          32'h0);
    check("rst_pc4",     pc_plus4,    32'h4);
    check("rst_instr",   instruction, 32'h0);
    check("rst_ivalid",  {31'b0, instr_valid}, 32'h0);
    check("rst_req",     {31'b0, imem_req},    32'h0);
    check("rst_err",     {31'b0, fetch_err},   32'h0);
    check("rst_instret", instret,     32'h0);
    reset     = 1'b0;
    m_pc      = 32'h0;
    m_instret = 32'h0;
  endtask

  // One full instruction: enter WAIT, respond after wait_cyc cycles, hold EXEC
  // for stall_cyc extra cycles, then check the redirect. Called at a falling
  // edge while the DUT is in FETCH.
  task automatic do_instr(input string name, input logic [31:0] rdata,
                          input int wait_cyc, input int stall_cyc,
                          input logic [1:0] jmp, input logic br,
                          input logic [25:0] tgt, input logic [15:0] imm,
                          input logic [31:0] rs, input logic zero,
                          input logic [31:0] exp_pc, input logic exp_err);
    logic [31:0] exp_instr;
    @(negedge clk);
    check({name, ":req"},  {31'b0, imem_req}, 32'h1);
    check({name, ":addr"}, imem_addr, m_pc);
    repeat (wait_cyc) @(negedge clk);
    imem_valid = 1'b1;
    imem_rdata = rdata;
    sb_q.push_back(rdata);
    @(negedge clk);
    imem_valid = 1'b0;
    imem_rdata = $urandom;
    exp_instr  = sb_q.pop_front();
    check({name, ":instr"},  instruction, exp_instr);
    check({name, ":ivalid"}, {31'b0, instr_valid}, 32'h1);
    check({name, ":req_ex"}, {31'b0, imem_req},    32'h0);
    check({name, ":pc4"},    pc_plus4, m_pc + 32'd4);
    jump      = jmp;
    branch    = br;
    target    = tgt;
    immediate = imm;
    rs_value  = rs;
    alu_zero  = zero;
    stall     = (stall_cyc > 0);
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      check({name, ":stl_iv"},  {31'b0, instr_valid}, 32'h1);
      check({name, ":stl_ins"}, instruction, exp_instr);
      check({name, ":stl_pc"},  pc, m_pc);
      check({name, ":stl_ret"}, instret, m_instret);
      if (i == stall_cyc - 1) stall = 1'b0;
    end
    @(negedge clk);
    m_instret = m_instret + 32'd1;
    if (!exp_err) m_pc = exp_pc;
    check({name, ":pc"},      pc, m_pc);
    check({name, ":instret"}, instret, m_instret);
    check({name, ":err"},     {31'b0, fetch_err},   {31'b0, exp_err});
    check({name, ":iv_off"},  {31'b0, instr_valid}, 32'h0);
    if (exp_err) begin
      repeat (3) @(negedge clk);
      check({name, ":halt_req"}, {31'b0, imem_req},    32'h0);
      check({name, ":halt_iv"},  {31'b0, instr_valid}, 32'h0);
      check({name, ":halt_pc"},  pc, m_pc);
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    idle_inputs();
    apply_reset(2);

    // name, rdata, wait, stall, jump, br, target, imm, rs, zero, exp_pc, exp_err
    do_instr("addi",   32'h2008_0005, 0, 0, JUMP_SEQ, 1'b0, 26'h0,   16'h0,    32'h0,         1'b0, 32'h0000_0004, 1'b0);
    do_instr("jr_hi",  32'h0120_0008, 2, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'h1000_0000, 1'b0, 32'h1000_0000, 1'b0);
    do_instr("j",      32'h0800_0010, 1, 0, JUMP_TGT, 1'b0, 26'h10,  16'h0,    32'h0,         1'b0, 32'h1000_0040, 1'b0);
    do_instr("jr_20",  32'h0120_0008, 0, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0);
    do_instr("bne_t",  32'h1509_FFFE, 0, 0, JUMP_SEQ, 1'b1, 26'h0,   16'hFFFE, 32'h0,         1'b0, 32'h0000_001C, 1'b0);
    do_instr("jr_20b", 32'h0120_0008, 3, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'h0000_0020, 1'b0, 32'h0000_0020, 1'b0);
    do_instr("bne_nt", 32'h1509_FFFE, 0, 0, JUMP_SEQ, 1'b1, 26'h0,   16'hFFFE, 32'h0,         1'b1, 32'h0000_0024, 1'b0);
    do_instr("jmp11",  32'h1509_0001, 0, 0, 2'b11,    1'b1, 26'h3FF, 16'h0001, 32'h0,         1'b0, 32'h0000_002C, 1'b0);
    do_instr("jr_top", 32'h0120_0008, 0, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'hFFFF_FFFC, 1'b0, 32'hFFFF_FFFC, 1'b0);
    do_instr("wrap",   32'h0000_0000, 0, 0, JUMP_SEQ, 1'b0, 26'h0,   16'h0,    32'h0,         1'b0, 32'h0000_0000, 1'b0);
    do_instr("stall",  32'hABCD_1234, 1, 5, JUMP_TGT, 1'b1, 26'h40,  16'h0004, 32'h0,         1'b0, 32'h0000_0100, 1'b0);
    do_instr("jr_ok",  32'h0120_0008, 0, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0);
    do_instr("jr_mis", 32'h0120_0008, 0, 0, JUMP_REG, 1'b0, 26'h0,   16'h0,    32'h0000_0102, 1'b0, 32'h0000_0100, 1'b1);

    // Response timeout: the 16th WAIT cycle without valid raises fetch_err.
    apply_reset(1);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i == 16) begin
        check("to_err_pre", {31'b0, fetch_err}, 32'h0);
        check("to_req_pre", {31'b0, imem_req},  32'h1);
      end
      if (i == 17) begin
        check("to_err",   {31'b0, fetch_err}, 32'h1);
        check("to_req",   {31'b0, imem_req},  32'h0);
        check("to_ivld",  {31'b0, instr_valid}, 32'h0);
      end
    end

    // Reset from HALT, then reset arriving with a response in WAIT.
    apply_reset(1);
    @(negedge clk);
    check("rw_req", {31'b0, imem_req}, 32'h1);
    reset      = 1'b1;
    imem_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("rw_instr",  instruction, 32'h0);
    check("rw_ivalid", {31'b0, instr_valid}, 32'h0);
    check("rw_req0",   {31'b0, imem_req},    32'h0);
    reset      = 1'b0;
    imem_valid = 1'b0;
    m_pc       = 32'h0;
    m_instret  = 32'h0;
    do_instr("after_rw", 32'h2008_0005, 0, 0, JUMP_SEQ, 1'b0, 26'h0, 16'h0, 32'h0, 1'b0, 32'h0000_0004, 1'b0);

    check("sb_empty", sb_q.size(), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
